// File: rtl/jtopl_eg_pkg.sv
// Shared envelope-generator constants: ADSR state codes, rate step patterns, maximum attenuation.
// Used by jtopl_eg_step and jtopl_eg_inc (optional JTOPL_EG_FORCE_EN adds a test_fast input).
package jtopl_eg_pkg;

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY   = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } eg_state_t;

    // Rows are indexed by rate[1:0]. Each row is written as an 8-position pattern;
    // counter position p selects the character at position p counting from the left.
    localparam logic [3:0][7:0] STEP_TBL = {
        8'b01111111,
        8'b01110111,
        8'b01110101,
        8'b01010101
    };

    localparam int EG_MAX = 511;

    function automatic logic step_bit(input logic [1:0] row, input logic [2:0] pos);
        return STEP_TBL[row][3'd7 - pos];
    endfunction

endpackage

// File: rtl/jtopl_eg_inc.sv
// Converts an effective rate plus the envelope counter/carry into an attenuation increment.
// With JTOPL_EG_FORCE_EN, test_fast forces a step on every sample for any nonzero rate.
module jtopl_eg_inc
    import jtopl_eg_pkg::*;
#(
    parameter int CNTW = 15
) (
    input  logic [5:0]      rate,
    input  logic [CNTW-1:0] eg_cnt,
    input  logic [CNTW-1:0] eg_carry,
`ifdef JTOPL_EG_FORCE_EN
    input  logic            test_fast,
`endif
    output logic [3:0]      inc
);

    logic [3:0] rate_hi;
    logic [1:0] rate_lo;
    logic [3:0] idx;
    logic       tick;
    logic [2:0] pos;
    logic       step;

    always_comb begin
        rate_hi = rate[5:2];
        rate_lo = rate[1:0];
        idx     = 4'd12 - rate_hi;
        tick    = 1'b0;
        pos     = eg_cnt[2:0];
        // Slow rates advance only when the selected counter bit carried this sample.
        if (rate_hi >= 4'd1 && rate_hi <= 4'd11) begin
            tick = eg_carry[idx - 4'd1];
            pos  = eg_cnt[idx +: 3];
        end
`ifdef JTOPL_EG_FORCE_EN
        if (test_fast) begin
            tick = 1'b1;
            pos  = 3'b111;
        end
`endif
        step = step_bit(rate_lo, pos);
        case (rate_hi)
            4'd0:    inc = 4'd0;
            4'd12:   inc = step ? 4'd2 : 4'd1;
            4'd13:   inc = step ? 4'd4 : 4'd2;
            4'd14:   inc = step ? 4'd8 : 4'd4;
            4'd15:   inc = 4'd8;
            default: inc = {3'b000, tick & step};
        endcase
    end

endmodule

// File: rtl/jtopl_eg_step.sv
// Per-slot ADSR step: reads slot state/attenuation from the EG ring and returns the update one cen later.
// Optional JTOPL_EG_FORCE_EN adds the test_fast input (every nonzero rate steps each sample).
module jtopl_eg_step
    import jtopl_eg_pkg::*;
#(
    parameter int EGW  = 9,
    parameter int CNTW = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [CNTW-1:0] eg_cnt,
    input  logic [CNTW-1:0] eg_carry,
    input  logic            keyon_now,
    input  logic            keyoff_now,
    input  logic [3:0]      ar,
    input  logic [3:0]      dr,
    input  logic [3:0]      rr,
    input  logic [3:0]      sl,
    input  logic            eg_type,
    input  logic            ksr,
    input  logic [3:0]      keycode,
    input  logic [1:0]      state_in,
    input  logic [EGW-1:0]  eg_in,
`ifdef JTOPL_EG_FORCE_EN
    input  logic            test_fast,
`endif
    output logic [1:0]      state_out,
    output logic [EGW-1:0]  eg_out,
    output logic            pg_rst
);

    eg_state_t      cur_state;
    eg_state_t      nxt_state;
    logic [EGW-1:0] nxt_eg;
    logic           nxt_pg;

    logic [3:0]     ks;
    logic [3:0]     base;
    logic [6:0]     rate_sum;
    logic [5:0]     rate;
    logic [3:0]     inc;
    logic [EGW+3:0] att_prod;
    logic [EGW:0]   att_sub;
    logic [EGW-1:0] att_eg;
    logic [EGW:0]   up_sum;
    logic [EGW-1:0] up_eg;
    logic [4:0]     sl_ext;

    always_comb begin
        cur_state = eg_state_t'(state_in);
        ks        = ksr ? keycode : {2'b00, keycode[3:2]};
        case (cur_state)
            ATTACK:  base = ar;
            DECAY:   base = dr;
            SUSTAIN: base = eg_type ? 4'd0 : rr;
            default: base = rr;
        endcase
        // A key-on update is judged at the attack rate.
        if (keyon_now) base = ar;
        rate_sum = {1'b0, base, 2'b00} + {3'b000, ks};
        if (base == 4'd0)
            rate = 6'd0;
        else if (rate_sum > 7'd63)
            rate = 6'd63;
        else
            rate = rate_sum[5:0];
    end

    jtopl_eg_inc #(.CNTW(CNTW)) u_inc (
        .rate      (rate),
        .eg_cnt    (eg_cnt),
        .eg_carry  (eg_carry),
`ifdef JTOPL_EG_FORCE_EN
        .test_fast (test_fast),
`endif
        .inc       (inc)
    );

    always_comb begin
        att_prod = ({4'b0000, eg_in} + 1'b1) * {{EGW{1'b0}}, inc};
        att_sub  = att_prod[EGW+3:3];
        att_eg   = ({1'b0, eg_in} >= att_sub) ? eg_in - att_sub[EGW-1:0] : '0;
        up_sum   = {1'b0, eg_in} + {{(EGW-3){1'b0}}, inc};
        up_eg    = up_sum[EGW] ? '1 : up_sum[EGW-1:0];
        sl_ext   = (sl == 4'hF) ? 5'd31 : {1'b0, sl};
    end

    always_comb begin
        nxt_state = cur_state;
        nxt_eg    = eg_in;
        nxt_pg    = 1'b0;
        if (keyon_now) begin
            nxt_state = ATTACK;
            nxt_pg    = 1'b1;
            if (rate >= 6'd60) begin
                nxt_eg    = '0;
                nxt_state = DECAY;
            end
        end else if (keyoff_now) begin
            nxt_state = RELEASE;
        end else begin
            case (cur_state)
                ATTACK: begin
                    nxt_eg = att_eg;
                    if (att_eg == '0) nxt_state = DECAY;
                end
                DECAY: begin
                    nxt_eg = up_eg;
                    if (up_eg[EGW-1:EGW-5] >= sl_ext) nxt_state = SUSTAIN;
                end
                default: nxt_eg = up_eg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_out <= RELEASE;
            eg_out    <= EGW'(EG_MAX);
            pg_rst    <= 1'b0;
        end else if (cen) begin
            state_out <= nxt_state;
            eg_out    <= nxt_eg;
            pg_rst    <= nxt_pg;
        end
    end

endmodule

// File: tb/tb_jtopl_eg_step.sv
// Bench for jtopl_eg_step: directed vector table, ring-feedback sequences and randomized model checks.
// Builds with or without JTOPL_EG_FORCE_EN (test_fast held low).
module tb_jtopl_eg_step;

    typedef struct {
        logic        keyon, keyoff;
        logic [3:0]  ar, dr, rr, sl;
        logic        eg_type, ksr;
        logic [3:0]  keycode;
        logic [1:0]  state_in;
        logic [8:0]  eg_in;
        logic [14:0] cnt, carry;
        int          exp_state, exp_eg, exp_pg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic [14:0] eg_cnt = '0, eg_carry = '0;
    logic        keyon_now = 1'b0, keyoff_now = 1'b0;
    logic [3:0]  ar = '0, dr = '0, rr = '0, sl = '0;
    logic        eg_type = 1'b0, ksr = 1'b0;
    logic [3:0]  keycode = '0;
    logic [1:0]  state_in = 2'd3;
    logic [8:0]  eg_in = 9'd511;
    logic [1:0]  state_out;
    logic [8:0]  eg_out;
    logic        pg_rst;

    int n_checks = 0;
    int n_fail   = 0;

    // Step patterns as written, position 0 on the left.
    int step_tab [4][8] = '{
        '{0,1,0,1,0,1,0,1},
        '{0,1,1,1,0,1,0,1},
        '{0,1,1,1,0,1,1,1},
        '{0,1,1,1,1,1,1,1}
    };

    always #5 clk = ~clk;

    jtopl_eg_step dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .eg_cnt     (eg_cnt),
        .eg_carry   (eg_carry),
        .keyon_now  (keyon_now),
        .keyoff_now (keyoff_now),
        .ar         (ar),
        .dr         (dr),
        .rr         (rr),
        .sl         (sl),
        .eg_type    (eg_type),
        .ksr        (ksr),
        .keycode    (keycode),
        .state_in   (state_in),
        .eg_in      (eg_in),
`ifdef JTOPL_EG_FORCE_EN
        .test_fast  (1'b0),
`endif
        .state_out  (state_out),
        .eg_out     (eg_out),
        .pg_rst     (pg_rst)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int kon, koff, a, d, r, s, et, kr, kc, st, eg, cn, ca,
                                input int est, eeg, epg);
        vec_t v;
        v.keyon = kon[0]; v.keyoff = koff[0];
        v.ar = a[3:0]; v.dr = d[3:0]; v.rr = r[3:0]; v.sl = s[3:0];
        v.eg_type = et[0]; v.ksr = kr[0]; v.keycode = kc[3:0];
        v.state_in = st[1:0]; v.eg_in = eg[8:0]; v.cnt = cn[14:0]; v.carry = ca[14:0];
        v.exp_state = est; v.exp_eg = eeg; v.exp_pg = epg;
        return v;
    endfunction

    // Reference: rate -> increment -> envelope rules, in plain integer arithmetic.
    function automatic void model(input vec_t v, output int st, output int eg, output int pg);
        int base, ks, rate, rh, rl, inc, idx, tick, pos, sub, slx;
        ks = v.ksr ? int'(v.keycode) : int'(v.keycode) / 4;
        if (v.keyon) base = v.ar;
        else case (v.state_in)
            0: base = v.ar;
            1: base = v.dr;
            2: base = v.eg_type ? 0 : int'(v.rr);
            default: base = v.rr;
        endcase
        rate = (base == 0) ? 0 : ((base * 4 + ks > 63) ? 63 : base * 4 + ks);
        rh = rate / 4;
        rl = rate % 4;
        if (rh == 0) inc = 0;
        else if (rh <= 11) begin
            idx  = 12 - rh;
            tick = (int'(v.carry) >> (idx - 1)) & 1;
            pos  = (int'(v.cnt) >> idx) & 7;
            inc  = (tick == 1 && step_tab[rl][pos] == 1) ? 1 : 0;
        end else if (rh <= 14) begin
            inc = (1 << (rh - 12)) * (step_tab[rl][int'(v.cnt) & 7] == 1 ? 2 : 1);
        end else inc = 8;
        slx = (v.sl == 15) ? 31 : int'(v.sl);
        st = v.state_in; eg = v.eg_in; pg = 0;
        if (v.keyon) begin
            st = 0; pg = 1;
            if (rate >= 60) begin eg = 0; st = 1; end
        end else if (v.keyoff) st = 3;
        else if (v.state_in == 0) begin
            sub = ((int'(v.eg_in) + 1) * inc) / 8;
            eg  = int'(v.eg_in) - sub;
            if (eg <= 0) begin eg = 0; st = 1; end
        end else begin
            eg = int'(v.eg_in) + inc;
            if (eg > 511) eg = 511;
            if (v.state_in == 1 && eg / 16 >= slx) st = 2;
        end
    endfunction

    task automatic drive(input vec_t v);
        keyon_now = v.keyon; keyoff_now = v.keyoff;
        ar = v.ar; dr = v.dr; rr = v.rr; sl = v.sl;
        eg_type = v.eg_type; ksr = v.ksr; keycode = v.keycode;
        state_in = v.state_in; eg_in = v.eg_in; eg_cnt = v.cnt; eg_carry = v.carry;
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v);
        cen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
    endtask

    vec_t tbl [13];
    vec_t v;
    int   es, ee, ep;

    initial begin
        // kon koff ar dr rr sl et ksr kc  st  eg   cnt  carry      est eeg  epg
        tbl[0]  = mk(1, 0, 15, 0,  0, 15, 0, 0, 0,  3, 511, 0,   0,         1, 0,   1);
        tbl[1]  = mk(0, 0, 12, 0,  0, 15, 0, 0, 0,  0, 511, 7,   0,         0, 383, 0);
        tbl[2]  = mk(0, 0, 0,  1,  0, 15, 0, 0, 0,  1, 100, 0,   0,         1, 100, 0);
        tbl[3]  = mk(0, 0, 0,  1,  0, 15, 0, 0, 0,  1, 100, 2048, 1024,     1, 101, 0);
        tbl[4]  = mk(0, 0, 0,  1,  0, 2,  0, 0, 0,  1, 31,  2048, 1024,     2, 32,  0);
        tbl[5]  = mk(0, 0, 0,  0,  15, 2, 1, 0, 0,  2, 32,  7,   32767,     2, 32,  0);
        tbl[6]  = mk(0, 0, 0,  0,  15, 0, 0, 0, 0,  3, 507, 0,   0,         3, 511, 0);
        tbl[7]  = mk(0, 0, 0,  0,  15, 0, 0, 0, 0,  3, 511, 0,   0,         3, 511, 0);
        tbl[8]  = mk(1, 1, 4,  0,  0,  0, 0, 0, 0,  3, 300, 0,   0,         0, 300, 1);
        tbl[9]  = mk(0, 1, 0,  0,  0,  0, 0, 0, 0,  1, 200, 0,   0,         3, 200, 0);
        tbl[10] = mk(0, 0, 15, 0,  0,  0, 0, 0, 0,  0, 100, 0,   0,         1, 0,   0);
        tbl[11] = mk(0, 0, 0,  12, 0, 15, 0, 1, 15, 1, 10,  0,   0,         1, 18,  0);
        tbl[12] = mk(0, 0, 0,  0,  13, 0, 0, 0, 0,  2, 40,  1,   0,         2, 44,  0);

        // Reset values, then hold while cen stays low.
        #12;
        check("reset_state", state_out, 3);
        check("reset_eg", eg_out, 511);
        check("reset_pg", pg_rst, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(tbl[0]);
        repeat (3) @(posedge clk);
        #1;
        check("hold_state", state_out, 3);
        check("hold_eg", eg_out, 511);
        check("hold_pg", pg_rst, 0);

        foreach (tbl[i]) begin
            step(tbl[i]);
            check($sformatf("vec%0d_state", i), state_out, tbl[i].exp_state);
            check($sformatf("vec%0d_eg", i), eg_out, tbl[i].exp_eg);
            check($sformatf("vec%0d_pg", i), pg_rst, tbl[i].exp_pg);
        end

        // Sustain with eg_type=1 holds through the ring for 100 samples.
        v = tbl[5];
        for (int i = 0; i < 100; i++) begin
            v.cnt   = 15'($urandom_range(0, 32767));
            v.carry = 15'($urandom_range(0, 32767));
            step(v);
            check("sustain_hold", eg_out, 32);
            v.state_in = state_out;
            v.eg_in    = eg_out;
        end
        check("sustain_state", state_out, 2);

        // Release from 507 saturates at 511 and stays there.
        v = tbl[6];
        for (int i = 0; i < 5; i++) begin
            step(v);
            check("release_sat", eg_out, 511);
            v.state_in = state_out;
            v.eg_in    = eg_out;
        end

        // Randomized slots against the reference model.
        for (int i = 0; i < 400; i++) begin
            v.keyon    = ($urandom_range(0, 9) == 0);
            v.keyoff   = ($urandom_range(0, 9) == 0);
            v.ar       = 4'($urandom_range(0, 15));
            v.dr       = 4'($urandom_range(0, 15));
            v.rr       = 4'($urandom_range(0, 15));
            v.sl       = 4'($urandom_range(0, 15));
            v.eg_type  = 1'($urandom_range(0, 1));
            v.ksr      = 1'($urandom_range(0, 1));
            v.keycode  = 4'($urandom_range(0, 15));
            v.state_in = 2'($urandom_range(0, 3));
            v.eg_in    = 9'($urandom_range(0, 511));
            v.cnt      = 15'($urandom_range(0, 32767));
            v.carry    = 15'($urandom_range(0, 32767));
            model(v, es, ee, ep);
            step(v);
            check("rand_state", state_out, es);
            check("rand_eg", eg_out, ee);
            check("rand_pg", pg_rst, ep);
        end

        // Asynchronous reset between clock edges.
        step(tbl[0]);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_state", state_out, 3);
        check("midrst_eg", eg_out, 511);
        check("midrst_pg", pg_rst, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
